thread_fetch_scheduler: RTL and testbench
=========================================

Name: thread_fetch_scheduler

Overview:
- Fine-grained multithread scheduler that sits in front of instruction fetch. It holds one PC per hardware thread and picks one eligible thread per cycle, round-robin.
- Issues {pc, thread_id} into the fetch/decode pipeline.
- Blocks a thread from the moment decode flags a beq/bneq until execute resolves it, then applies the redirect.
- Also lets control software load a thread's start PC and enable or disable threads.

Parameters:
- INST_ADDR_WIDTH, 9, instruction address width (per-thread PC width).
- THREAD_BITS, 2, thread id width.
- NUM_THREADS, 4, thread count; must equal 2**THREAD_BITS.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global pipeline advance; 0 = stall.
- thread_enable  in  NUM_THREADS  per-thread run mask.
- pc_load  in  1  write start PC.
- pc_load_thread  in  THREAD_BITS  thread targeted by pc_load.
- pc_load_value  in  INST_ADDR_WIDTH  start PC value.
- dec_branch  in  1  decode stage holds a beq/bneq.
- dec_thread_id  in  THREAD_BITS  thread of that decoded branch.
- br_resolve  in  1  execute stage resolved a branch.
- br_thread_id  in  THREAD_BITS  thread of the resolved branch.
- br_taken  in  1  resolved branch taken.
- br_target  in  INST_ADDR_WIDTH  taken target.
- fetch_valid  out  1  fetch_pc/fetch_thread_id are a real issue this cycle.
- fetch_pc  out  INST_ADDR_WIDTH  PC issued to instruction memory.
- fetch_thread_id  out  THREAD_BITS  issuing thread.
- thread_blocked  out  NUM_THREADS  per-thread branch-pending flags.
- idle  out  1  no thread enabled.

Behaviour:
- State:
  - pc[NUM_THREADS]
  - blocked[NUM_THREADS]
  - last_grant (THREAD_BITS)
  - cooldown (1 bit: last_grant was granted in the previous advancing cycle)
- Reset (async, immediate) values:
  - all pc = 0, blocked = 0.
  - last_grant = NUM_THREADS-1, so thread 0 is searched first.
  - cooldown = 0.
  - fetch_valid = 0, fetch_pc = 0, fetch_thread_id = 0.
  - thread_blocked = 0; idle reflects thread_enable combinationally.
- Eligibility: eligible[t] = thread_enable[t] & ~blocked[t] & ~(cooldown & t==last_grant).
  - Cooldown guarantees decode has flagged a branch before the same thread can issue again.
  - A lone thread therefore issues at most every other cycle.
- Grant: first eligible thread searching last_grant+1, last_grant+2, … modulo NUM_THREADS.
- Advancing cycle (en=1) with a grant g, registered (latency 1: outputs valid the cycle after the decision):
  - fetch_valid <= 1, fetch_pc <= pc[g], fetch_thread_id <= g.
  - pc[g] <= pc[g]+1, wrapping modulo 2**INST_ADDR_WIDTH.
  - last_grant <= g, cooldown <= 1.
- Advancing cycle with no eligible thread:
  - fetch_valid <= 0; fetch_pc and fetch_thread_id hold.
  - cooldown <= 0; last_grant holds.
- en=0: fetch_*, last_grant, cooldown and PC increments are frozen.
  - dec_branch, br_resolve and pc_load are still applied; all three are idempotent if held during a stall.
- dec_branch: blocked[dec_thread_id] <= 1.
- br_resolve: blocked[br_thread_id] <= 0.
  - If br_taken: pc[br_thread_id] <= br_target.
  - Not taken: pc already points past the branch and is unchanged.
- Same-cycle priority per thread, highest first:
  1. pc_load (pc <= pc_load_value, blocked <= 0)
  2. br_resolve redirect
  3. grant increment
- Same-cycle block/clear: dec_branch set beats br_resolve clear on the same thread.
- A blocked thread is never granted, so resolve and increment cannot collide on one thread.
- Disabling a thread mid-flight: it stops being granted immediately; pc and blocked are retained.
- thread_blocked = blocked. idle = ~|thread_enable.

Decomposition:
- Shared package (with the pipeline registers and decoder):
  - NUM_THREADS, THREAD_BITS, INST_ADDR_WIDTH.
  - thread_id typedef; pc typedef.
- Sub-module rr_pick: purely combinational round-robin selector.
  - Inputs: request mask, last_grant.
  - Outputs: grant_valid, grant_id.
- The scheduler instantiates rr_pick once and owns all registers.

Test Plan:
- Reset, all 4 threads enabled, en=1 → fetch_thread_id sequence 0,1,2,3,0… with fetch_valid=1 every cycle. Each thread's fetch_pc increments by 1 per own issue, starting from 0.
- Only thread 2 enabled, pc_load thread 2 = 0x100 → fetch_pc 0x100, bubble, 0x101, bubble (cooldown alternation).
- Threads 0,1 enabled; dec_branch for thread 0 while it holds pc 0x005 → only thread 1 issues. br_resolve taken to 0x040 → thread 0 resumes at 0x040. Repeat not-taken → thread 0 resumes at 0x005.
- Thread 3 pc = 0x1FF issues → next issue of thread 3 at 0x000 (wrap).
- en held 0 for 3 cycles mid-stream → outputs and grant order frozen, sequence continues unchanged on release. br_resolve during the stall still clears the block.
- Same cycle on thread 1: pc_load 0x020 and br_resolve taken 0x080 → pc=0x020, unblocked. Assert reset asynchronously mid-stream → fetch_valid=0 without a clock edge.

Source files
------------

// File: rtl/thread_fetch_scheduler_pkg.sv
// Shared sizing and types for the thread fetch scheduler.
package thread_fetch_scheduler_pkg;
  localparam int INST_ADDR_WIDTH = 9;
  localparam int THREAD_BITS     = 2;
  localparam int NUM_THREADS     = 2 ** THREAD_BITS;

  typedef logic [THREAD_BITS-1:0]     thread_id_t;
  typedef logic [INST_ADDR_WIDTH-1:0] pc_t;
endpackage

// File: rtl/thread_fetch_scheduler_rr_pick.sv
// Combinational round-robin selector: first requester after last_grant, wrapping.
module rr_pick
  import thread_fetch_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_THREADS,
  parameter int ID_BITS = THREAD_BITS
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] last_grant,
  output logic               grant_valid,
  output logic [ID_BITS-1:0] grant_id
);
  logic [ID_BITS-1:0] idx;

  // Walk last_grant+1 .. last_grant+NUM_REQ; the id width makes the wrap free.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = last_grant;
    idx         = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_grant + ID_BITS'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end
endmodule

// File: rtl/thread_fetch_scheduler.sv
// Per-thread PC holder and round-robin fetch issuer with branch blocking.
module thread_fetch_scheduler
  import thread_fetch_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic                   pc_load,
  input  thread_id_t             pc_load_thread,
  input  pc_t                    pc_load_value,
  input  logic                   dec_branch,
  input  thread_id_t             dec_thread_id,
  input  logic                   br_resolve,
  input  thread_id_t             br_thread_id,
  input  logic                   br_taken,
  input  pc_t                    br_target,
  output logic                   fetch_valid,
  output pc_t                    fetch_pc,
  output thread_id_t             fetch_thread_id,
  output logic [NUM_THREADS-1:0] thread_blocked,
  output logic                   idle
);
  pc_t [NUM_THREADS-1:0]  pc;
  logic [NUM_THREADS-1:0] blocked;
  logic [NUM_THREADS-1:0] eligible;
  thread_id_t             last_grant;
  thread_id_t             grant_id;
  logic                   cooldown;
  logic                   grant_valid;
  logic                   advance;

  assign advance = en && grant_valid;

  // A thread may issue when enabled, not waiting on a branch, and not the one
  // that issued last cycle (decode needs that cycle to flag a branch).
  always_comb begin
    eligible = '0;
    for (int t = 0; t < NUM_THREADS; t++)
      eligible[t] = thread_enable[t] && !blocked[t] &&
                    !(cooldown && (last_grant == thread_id_t'(t)));
  end

  rr_pick #(.NUM_REQ(NUM_THREADS), .ID_BITS(THREAD_BITS)) u_pick (
    .req        (eligible),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // Per-thread PC and block flag; load beats redirect beats issue increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      blocked <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (pc_load && pc_load_thread == thread_id_t'(t))
          pc[t] <= pc_load_value;
        else if (br_resolve && br_taken && br_thread_id == thread_id_t'(t))
          pc[t] <= br_target;
        else if (advance && grant_id == thread_id_t'(t))
          pc[t] <= pc[t] + 1'b1;

        if (pc_load && pc_load_thread == thread_id_t'(t))
          blocked[t] <= 1'b0;
        else if (dec_branch && dec_thread_id == thread_id_t'(t))
          blocked[t] <= 1'b1;
        else if (br_resolve && br_thread_id == thread_id_t'(t))
          blocked[t] <= 1'b0;
      end
    end
  end

  // Issue register and round-robin pointer; everything frozen while en=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid     <= 1'b0;
      fetch_pc        <= '0;
      fetch_thread_id <= '0;
      last_grant      <= thread_id_t'(NUM_THREADS - 1);
      cooldown        <= 1'b0;
    end else if (en) begin
      if (grant_valid) begin
        fetch_valid     <= 1'b1;
        fetch_pc        <= pc[grant_id];
        fetch_thread_id <= grant_id;
        last_grant      <= grant_id;
        cooldown        <= 1'b1;
      end else begin
        fetch_valid <= 1'b0;
        cooldown    <= 1'b0;
      end
    end
  end

  assign thread_blocked = blocked;
  assign idle           = ~|thread_enable;
endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Randomized and directed bench for thread_fetch_scheduler against a queue-free
// behavioural model of the issue rules.
module tb_thread_fetch_scheduler;
  import thread_fetch_scheduler_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   en;
  logic [NUM_THREADS-1:0] thread_enable;
  logic                   pc_load;
  thread_id_t             pc_load_thread;
  pc_t                    pc_load_value;
  logic                   dec_branch;
  thread_id_t             dec_thread_id;
  logic                   br_resolve;
  thread_id_t             br_thread_id;
  logic                   br_taken;
  pc_t                    br_target;
  logic                   fetch_valid;
  pc_t                    fetch_pc;
  thread_id_t             fetch_thread_id;
  logic [NUM_THREADS-1:0] thread_blocked;
  logic                   idle;

  thread_fetch_scheduler dut (
    .clk(clk), .reset(reset), .en(en), .thread_enable(thread_enable),
    .pc_load(pc_load), .pc_load_thread(pc_load_thread), .pc_load_value(pc_load_value),
    .dec_branch(dec_branch), .dec_thread_id(dec_thread_id),
    .br_resolve(br_resolve), .br_thread_id(br_thread_id), .br_taken(br_taken),
    .br_target(br_target), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_thread_id(fetch_thread_id), .thread_blocked(thread_blocked), .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int       m_pc [NUM_THREADS];
  bit [3:0] m_blk;
  int       m_last;
  bit       m_cool;
  bit       m_fv;
  int       m_fpc;
  int       m_ftid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NUM_THREADS; t++) m_pc[t] = 0;
    m_blk = '0; m_last = NUM_THREADS - 1; m_cool = 0;
    m_fv = 0; m_fpc = 0; m_ftid = 0;
  endtask

  // One clock of the rules, from the inputs currently driven.
  task automatic model_step();
    int g = -1;
    int npc [NUM_THREADS];
    for (int k = 1; k <= NUM_THREADS && g < 0; k++) begin
      int t = (m_last + k) % NUM_THREADS;
      if (thread_enable[t] && !m_blk[t] && !(m_cool && t == m_last)) g = t;
    end
    for (int t = 0; t < NUM_THREADS; t++) npc[t] = m_pc[t];
    if (en) begin
      if (g >= 0) begin
        m_fv = 1; m_fpc = m_pc[g]; m_ftid = g;
        npc[g] = (m_pc[g] + 1) % (1 << INST_ADDR_WIDTH);
        m_last = g; m_cool = 1;
      end else begin
        m_fv = 0; m_cool = 0;
      end
    end
    // later writes win: lowest priority first
    if (br_resolve && br_taken) npc[br_thread_id] = br_target;
    if (pc_load) npc[pc_load_thread] = pc_load_value;
    if (br_resolve) m_blk[br_thread_id] = 1'b0;
    if (dec_branch) m_blk[dec_thread_id] = 1'b1;
    if (pc_load)    m_blk[pc_load_thread] = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) m_pc[t] = npc[t];
  endtask

  task automatic check_all();
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
    chk("fetch_thread_id", 32'(fetch_thread_id), 32'(m_ftid));
    chk("thread_blocked", 32'(thread_blocked), 32'(m_blk));
    chk("idle", 32'(idle), 32'(thread_enable == '0));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic issue_wait(input int tid, input int exp_pc, input string name);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      if (fetch_valid && fetch_thread_id == thread_id_t'(tid)) begin
        seen = 1;
        chk(name, 32'(fetch_pc), 32'(exp_pc));
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s: thread %0d never issued within 10 cycles", name, tid);
    end
  endtask

  initial begin
    logic       sv_fv;
    int         sv_pc, sv_tid;
    reset = 1'b1; en = 1'b0; thread_enable = '0;
    pc_load = 0; pc_load_thread = '0; pc_load_value = '0;
    dec_branch = 0; dec_thread_id = '0;
    br_resolve = 0; br_thread_id = '0; br_taken = 0; br_target = '0;
    model_reset();
    #12;
    chk("reset fetch_valid", 32'(fetch_valid), 0);
    chk("reset fetch_pc", 32'(fetch_pc), 0);
    chk("reset thread_blocked", 32'(thread_blocked), 0);
    chk("reset idle", 32'(idle), 1);
    reset = 1'b0;

    // all four threads: 0,1,2,3,0 with pcs 0,0,0,0,1
    thread_enable = 4'hF; en = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr valid", 32'(fetch_valid), 1);
      chk("rr tid", 32'(fetch_thread_id), 32'(k % 4));
      chk("rr pc", 32'(fetch_pc), 32'(k / 4));
    end

    // lone thread 2 alternates with bubbles
    en = 0; thread_enable = 4'b0100;
    pc_load = 1; pc_load_thread = 2; pc_load_value = 9'h100;
    cyc();
    pc_load = 0; en = 1;
    cyc(); chk("solo valid0", 32'(fetch_valid), 1); chk("solo pc0", 32'(fetch_pc), 32'h100);
    cyc(); chk("solo bubble0", 32'(fetch_valid), 0);
    cyc(); chk("solo valid1", 32'(fetch_valid), 1); chk("solo pc1", 32'(fetch_pc), 32'h101);
    cyc(); chk("solo bubble1", 32'(fetch_valid), 0);

    // branch block on thread 0, taken then not-taken
    en = 0; thread_enable = 4'b0011;
    pc_load = 1; pc_load_thread = 0; pc_load_value = 9'h005; cyc();
    pc_load_thread = 1; pc_load_value = 9'h0A0; cyc();
    pc_load = 0; en = 1;
    issue_wait(0, 9'h005, "br issue 005");
    dec_branch = 1; dec_thread_id = 0; cyc(); dec_branch = 0;
    chk("blocked t0", 32'(thread_blocked), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t0 silent", 32'(fetch_valid && fetch_thread_id == 0), 0);
    end
    br_resolve = 1; br_thread_id = 0; br_taken = 1; br_target = 9'h040; cyc();
    br_resolve = 0;
    chk("unblocked t0", 32'(thread_blocked), 0);
    issue_wait(0, 9'h040, "taken resume");
    en = 0; pc_load = 1; pc_load_thread = 0; pc_load_value = 9'h004; cyc();
    pc_load = 0; en = 1;
    issue_wait(0, 9'h004, "br issue 004");
    dec_branch = 1; dec_thread_id = 0; cyc(); dec_branch = 0;
    cyc(); cyc();
    br_resolve = 1; br_thread_id = 0; br_taken = 0; cyc(); br_resolve = 0;
    issue_wait(0, 9'h005, "not-taken resume");

    // PC wrap on thread 3
    en = 0; thread_enable = 4'b1000;
    pc_load = 1; pc_load_thread = 3; pc_load_value = 9'h1FF; cyc();
    pc_load = 0; en = 1;
    issue_wait(3, 9'h1FF, "wrap top");
    issue_wait(3, 9'h000, "wrap zero");

    // stall with a resolve landing inside it
    thread_enable = 4'hF;
    cyc(); cyc(); cyc();
    dec_branch = 1; dec_thread_id = 1; cyc(); dec_branch = 0;
    sv_fv = m_fv; sv_pc = m_fpc; sv_tid = m_ftid;
    en = 0;
    for (int i = 0; i < 3; i++) begin
      br_resolve = (i == 1); br_thread_id = 1; br_taken = 0;
      cyc();
      chk("stall valid", 32'(fetch_valid), 32'(sv_fv));
      chk("stall pc", 32'(fetch_pc), 32'(sv_pc));
      chk("stall tid", 32'(fetch_thread_id), 32'(sv_tid));
    end
    br_resolve = 0;
    chk("stall resolve", 32'(thread_blocked[1]), 0);
    en = 1;
    for (int i = 0; i < 5; i++) cyc();

    // pc_load beats redirect on the same thread
    en = 0; dec_branch = 1; dec_thread_id = 1; cyc(); dec_branch = 0;
    chk("t1 blocked", 32'(thread_blocked[1]), 1);
    pc_load = 1; pc_load_thread = 1; pc_load_value = 9'h020;
    br_resolve = 1; br_thread_id = 1; br_taken = 1; br_target = 9'h080;
    cyc();
    pc_load = 0; br_resolve = 0;
    chk("load clears block", 32'(thread_blocked[1]), 0);
    en = 1;
    issue_wait(1, 9'h020, "load over redirect");

    // asynchronous reset without a clock edge
    cyc(); cyc();
    #2 reset = 1;
    #1;
    chk("async fetch_valid", 32'(fetch_valid), 0);
    chk("async fetch_pc", 32'(fetch_pc), 0);
    chk("async blocked", 32'(thread_blocked), 0);
    model_reset();
    reset = 0;

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if (n % 16 == 0) thread_enable = 4'($urandom);
      en             = ($urandom_range(0, 9) < 8);
      pc_load        = ($urandom_range(0, 19) == 0);
      pc_load_thread = thread_id_t'($urandom);
      pc_load_value  = pc_t'($urandom);
      dec_branch     = ($urandom_range(0, 9) == 0);
      dec_thread_id  = thread_id_t'($urandom);
      br_resolve     = ($urandom_range(0, 9) == 0);
      br_thread_id   = thread_id_t'($urandom);
      br_taken       = 1'($urandom);
      br_target      = pc_t'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
